// File: rtl/program_counter16.sv
// program_counter16: registered program counter with load, increment and a sticky wrap flag
module program_counter16 #(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             inc,
   input  logic [WIDTH-1:0] inAddr,
   output logic [WIDTH-1:0] out,
   output logic             wrapped
);
   logic [WIDTH-1:0] out_q, out_d;
   logic             wrapped_q, wrapped_d;
   logic [WIDTH:0]   sum;

   // next state: load beats inc beats hold; the carry out of the increment only feeds the sticky flag
   always_comb begin
      sum       = {1'b0, out_q} + {{WIDTH{1'b0}}, 1'b1};
      out_d     = load ? inAddr : inc ? sum[WIDTH-1:0] : out_q;
      wrapped_d = load ? 1'b0 : inc ? (wrapped_q | sum[WIDTH]) : wrapped_q;
   end

   // state registers with synchronous reset taking priority over every other control
   always_ff @(posedge clk) begin
      if (reset) begin
         out_q     <= RESET_VALUE;
         wrapped_q <= 1'b0;
      end else begin
         out_q     <= out_d;
         wrapped_q <= wrapped_d;
      end
   end

   assign out     = out_q;
   assign wrapped = wrapped_q;
endmodule

// File: tb/tb_program_counter16.sv
// tb_program_counter16: directed and randomized checks of program_counter16 against a reference model
module tb_program_counter16;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        load = 1'b0;
   logic        inc = 1'b0;
   logic [15:0] inAddr = '0;
   logic [15:0] out;
   logic        wrapped;
   int          checks = 0;
   int          errors = 0;
   int          m_out = 0;
   bit          m_wrap = 1'b0;

   program_counter16 #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut (
      .clk(clk), .reset(reset), .load(load), .inc(inc),
      .inAddr(inAddr), .out(out), .wrapped(wrapped)
   );

   always #5 clk = ~clk;

   // drive one edge's controls after the falling edge, update the reference model, sample 1 time unit after the edge
   task automatic step(input logic r, input logic l, input logic i, input logic [15:0] a);
      @(negedge clk);
      reset = r; load = l; inc = i; inAddr = a;
      @(posedge clk);
      if (r) begin
         m_out = 0; m_wrap = 1'b0;
      end else if (l) begin
         m_out = int'(a); m_wrap = 1'b0;
      end else if (i) begin
         if (m_out == 65535) m_wrap = 1'b1;
         m_out = (m_out + 1) % 65536;
      end
      #1;
   endtask

   task automatic test_reset;
      int e0 = errors;
      step(1'b1, 1'b0, 1'b0, 16'hBEEF);
      checks++;
      if (out !== 16'h0000 || wrapped !== 1'b0) begin
         errors++;
         $display("FAIL reset: out=%h wrapped=%b, expected 0000 0", out, wrapped);
      end
      for (int k = 1; k <= 3; k++) begin
         step(1'b0, 1'b0, 1'b1, 16'($urandom));
         checks++;
         if (out !== 16'(k) || wrapped !== 1'b0) begin
            errors++;
            $display("FAIL reset_inc[%0d]: out=%h wrapped=%b, expected %h 0", k, out, wrapped, 16'(k));
         end
      end
      if (errors == e0) $display("test_reset PASSED");
   endtask

   task automatic test_load;
      int e0 = errors;
      step(1'b0, 1'b1, 1'b1, 16'h1234);
      checks++;
      if (out !== 16'h1234 || wrapped !== 1'b0) begin
         errors++;
         $display("FAIL load_with_inc: out=%h wrapped=%b, expected 1234 0", out, wrapped);
      end
      for (int k = 0; k < 2; k++) begin
         step(1'b0, 1'b0, 1'b0, 16'($urandom));
         checks++;
         if (out !== 16'h1234 || wrapped !== 1'b0) begin
            errors++;
            $display("FAIL load_hold[%0d]: out=%h wrapped=%b, expected 1234 0", k, out, wrapped);
         end
      end
      @(negedge clk);
      load = 1'b1; inc = 1'b1; inAddr = 16'h5555;
      #2;
      checks++;
      if (out !== 16'h1234 || wrapped !== 1'b0) begin
         errors++;
         $display("FAIL load_no_early: out=%h wrapped=%b, expected 1234 0", out, wrapped);
      end
      load = 1'b0; inc = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (out !== 16'h1234 || wrapped !== 1'b0) begin
         errors++;
         $display("FAIL load_glitch_ignored: out=%h wrapped=%b, expected 1234 0", out, wrapped);
      end
      if (errors == e0) $display("test_load PASSED");
   endtask

   task automatic test_wrap;
      int e0 = errors;
      logic [15:0] exp_o [3] = '{16'hFFFF, 16'h0000, 16'h0001};
      logic        exp_w [3] = '{1'b0, 1'b1, 1'b1};
      step(1'b0, 1'b1, 1'b0, 16'hFFFE);
      checks++;
      if (out !== 16'hFFFE || wrapped !== 1'b0) begin
         errors++;
         $display("FAIL wrap_load: out=%h wrapped=%b, expected fffe 0", out, wrapped);
      end
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, 1'b1, 16'($urandom));
         checks++;
         if (out !== exp_o[k] || wrapped !== exp_w[k]) begin
            errors++;
            $display("FAIL wrap_inc[%0d]: out=%h wrapped=%b, expected %h %b", k, out, wrapped, exp_o[k], exp_w[k]);
         end
      end
      step(1'b0, 1'b1, 1'b0, 16'h0010);
      checks++;
      if (out !== 16'h0010 || wrapped !== 1'b0) begin
         errors++;
         $display("FAIL wrap_clear_by_load: out=%h wrapped=%b, expected 0010 0", out, wrapped);
      end
      if (errors == e0) $display("test_wrap PASSED");
   endtask

   task automatic test_reset_priority;
      int e0 = errors;
      step(1'b1, 1'b0, 1'b0, 16'h0000);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 16'($urandom));
      checks++;
      if (out !== 16'h0005) begin
         errors++;
         $display("FAIL prio_count: out=%h, expected 0005", out);
      end
      step(1'b1, 1'b1, 1'b1, 16'hABCD);
      checks++;
      if (out !== 16'h0000 || wrapped !== 1'b0) begin
         errors++;
         $display("FAIL prio_reset_over_load: out=%h wrapped=%b, expected 0000 0", out, wrapped);
      end
      step(1'b0, 1'b0, 1'b1, 16'hABCD);
      checks++;
      if (out !== 16'h0001 || wrapped !== 1'b0) begin
         errors++;
         $display("FAIL prio_first_after_reset: out=%h wrapped=%b, expected 0001 0", out, wrapped);
      end
      if (errors == e0) $display("test_reset_priority PASSED");
   endtask

   task automatic test_glitch_reset;
      int e0 = errors;
      step(1'b0, 1'b1, 1'b0, 16'h4321);
      @(negedge clk);
      load = 1'b0; inc = 1'b0;
      reset = 1'b1;
      #2;
      checks++;
      if (out !== 16'h4321 || wrapped !== 1'b0) begin
         errors++;
         $display("FAIL glitch_during: out=%h wrapped=%b, expected 4321 0", out, wrapped);
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (out !== 16'h4321 || wrapped !== 1'b0) begin
         errors++;
         $display("FAIL glitch_after_edge: out=%h wrapped=%b, expected 4321 0", out, wrapped);
      end
      if (errors == e0) $display("test_glitch_reset PASSED");
   endtask

   task automatic test_load_ones_inc;
      int e0 = errors;
      step(1'b0, 1'b1, 1'b0, 16'hFFFF);
      checks++;
      if (out !== 16'hFFFF || wrapped !== 1'b0) begin
         errors++;
         $display("FAIL ones_load: out=%h wrapped=%b, expected ffff 0", out, wrapped);
      end
      step(1'b0, 1'b0, 1'b1, 16'h0000);
      checks++;
      if (out !== 16'h0000 || wrapped !== 1'b1) begin
         errors++;
         $display("FAIL ones_inc: out=%h wrapped=%b, expected 0000 1", out, wrapped);
      end
      step(1'b0, 1'b0, 1'b0, 16'h7777);
      checks++;
      if (out !== 16'h0000 || wrapped !== 1'b1) begin
         errors++;
         $display("FAIL ones_sticky_hold: out=%h wrapped=%b, expected 0000 1", out, wrapped);
      end
      if (errors == e0) $display("test_load_ones_inc PASSED");
   endtask

   task automatic test_random;
      int e0 = errors;
      logic [15:0] a;
      logic r, l, i;
      step(1'b1, 1'b0, 1'b0, 16'h0000);
      for (int k = 0; k < 400; k++) begin
         r = ($urandom_range(0, 99) < 4);
         l = ($urandom_range(0, 99) < 15);
         i = ($urandom_range(0, 99) < 70);
         case ($urandom_range(0, 3))
            0: a = 16'hFFFF;
            1: a = 16'hFFFD;
            default: a = 16'($urandom);
         endcase
         step(r, l, i, a);
         checks++;
         if (out !== 16'(m_out) || wrapped !== m_wrap) begin
            errors++;
            $display("FAIL random[%0d] r=%b l=%b i=%b a=%h: out=%h wrapped=%b, expected %h %b", k, r, l, i, a, out, wrapped, 16'(m_out), m_wrap);
         end
      end
      if (errors == e0) $display("test_random PASSED");
   endtask

   initial begin
      test_reset;
      test_load;
      test_wrap;
      test_reset_priority;
      test_glitch_reset;
      test_load_ones_inc;
      test_random;
      if (errors == 0) $display("All tests PASSED");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
